// File: rtl/mov_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mov_sequencer
// Brief    : Expands a 64-bit constant + rd into a MOVZ/MOVK word stream.
// Revision : 1.0 - initial release
// ============================================================================
module mov_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        busy
);

    localparam logic [8:0] C_OPC_MOVZ = 9'b110100101;
    localparam logic [8:0] C_OPC_MOVK = 9'b111100101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] value_q, value_d;
    logic [4:0]  rd_q, rd_d;
    logic [3:0]  remain_q, remain_d;   // nonzero halfwords not yet emitted
    logic        first_q, first_d;

    logic [3:0]  w_in_nz;
    logic [3:0]  w_remain_next;
    logic [1:0]  w_cur_hw;
    logic [15:0] w_imm;
    logic        w_is_last;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_in_nz[i] = |in_value[16*i +: 16];
        end
    end

    // Lowest pending halfword; a zero constant has none and falls back to hw0.
    always_comb begin
        w_cur_hw = 2'd0;
        if (remain_q[0])      w_cur_hw = 2'd0;
        else if (remain_q[1]) w_cur_hw = 2'd1;
        else if (remain_q[2]) w_cur_hw = 2'd2;
        else if (remain_q[3]) w_cur_hw = 2'd3;
    end

    assign w_remain_next = remain_q & (remain_q - 4'd1);
    assign w_is_last     = (w_remain_next == 4'd0);

    always_comb begin
        w_imm = 16'h0;
        case (w_cur_hw)
            2'd0: w_imm = value_q[15:0];
            2'd1: w_imm = value_q[31:16];
            2'd2: w_imm = value_q[47:32];
            2'd3: w_imm = value_q[63:48];
            default: w_imm = 16'h0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        rd_d     = rd_q;
        remain_d = remain_q;
        first_d  = first_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d  = S_EMIT;
                    value_d  = in_value;
                    rd_d     = in_rd;
                    remain_d = w_in_nz;
                    first_d  = 1'b1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    first_d  = 1'b0;
                    remain_d = w_remain_next;
                    if (w_is_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            value_q  <= 64'h0;
            rd_q     <= 5'h0;
            remain_q <= 4'h0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            rd_q     <= rd_d;
            remain_q <= remain_d;
            first_q  <= first_d;
        end
    end

    // Outputs are decoded from registered state only and forced to zero in IDLE.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_EMIT);
        out_valid = busy;
        out_last  = busy & w_is_last;
        out_instr = 32'h0;
        if (busy) begin
            out_instr = {(first_q ? C_OPC_MOVZ : C_OPC_MOVK), w_cur_hw, w_imm, rd_q};
        end
    end

endmodule
`default_nettype wire
